// File: rtl/alu_bist.sv
// -----------------------------------------------------------------------------
// alu_bist -- built-in self test sequencer for a 32-bit combinational ALU.
//
// After a start request the block walks NUM_OPS opcodes, applying NUM_VECTORS
// pseudo-random operand pairs per opcode. The operands come from a Galois
// LFSR. Every ALU response, including its zero flag, is compressed into a
// 32-bit MISR. A separate saturating counter records every cycle in which the
// zero flag disagrees with the result. After the last vector the signature is
// compared against GOLDEN_SIG. The block then posts a held pass/fail verdict
// and a one-cycle done pulse.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   run request, only looked at while idle
//   bist_a       out  [31:0] operand a to the ALU (0 when not running)
//   bist_b       out  [31:0] operand b to the ALU (0 when not running)
//   bist_alu_op  out  [3:0]  opcode to the ALU (0 when not running)
//   alu_result   in   [31:0] ALU result (combinational from bist_*)
//   alu_zero     in   ALU zero flag
//   busy         out  high while a run is in progress (RUN and COMPARE)
//   done         out  one-cycle pulse when a run completes
//   pass         out  held pass verdict of the last completed run
//   fail         out  held fail verdict of the last completed run
//   signature    out  [31:0] current MISR value
//   zero_err_cnt out  [7:0] saturating count of zero-flag inconsistencies
// -----------------------------------------------------------------------------
module alu_bist #(
  parameter int unsigned NUM_OPS     = 10,
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_1234,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] bist_a,
  output logic [31:0] bist_b,
  output logic [3:0]  bist_alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] signature,
  output logic [7:0]  zero_err_cnt
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam int unsigned VEC_W     = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);
  localparam logic [3:0]       OP_LAST  = 4'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [31:0]      misr_q, misr_d;
  logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [3:0]       op_cnt_q, op_cnt_d;
  logic [7:0]       zerr_q, zerr_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;

  logic [31:0]      lfsr_step;
  logic [31:0]      misr_step;
  logic             zero_mismatch;
  logic             verdict_fail;

  // Right-shifting Galois LFSR: the bit that falls out of the LSB folds the
  // tap mask back in.
  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

  // The MISR absorbs the full result word. The zero flag is folded into bit 0
  // so that a stuck flag also shows up in the signature.
  always_comb begin
    misr_step    = {misr_q[30:0], 1'b0} ^ (misr_q[31] ? MISR_POLY : 32'h0) ^ alu_result;
    misr_step[0] = misr_step[0] ^ alu_zero;
  end

  assign zero_mismatch = (alu_zero != (alu_result == 32'h0));
  assign verdict_fail  = (misr_q != GOLDEN_SIG) || (zerr_q != 8'h00);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    vec_cnt_d = vec_cnt_q;
    op_cnt_d  = op_cnt_q;
    zerr_d    = zerr_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          lfsr_d    = LFSR_SEED;
          misr_d    = 32'h0;
          vec_cnt_d = '0;
          op_cnt_d  = 4'h0;
          zerr_d    = 8'h00;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
        end
      end

      ST_RUN: begin
        lfsr_d = lfsr_step;
        misr_d = misr_step;
        if (zero_mismatch && (zerr_q != 8'hFF)) begin
          zerr_d = zerr_q + 8'd1;
        end
        // Opcode-major walk: the opcode only moves once all of its vectors
        // have been applied.
        if (vec_cnt_q == VEC_LAST) begin
          vec_cnt_d = '0;
          if (op_cnt_q == OP_LAST) begin
            op_cnt_d = 4'h0;
            state_d  = ST_CMP;
          end else begin
            op_cnt_d = op_cnt_q + 4'd1;
          end
        end else begin
          vec_cnt_d = vec_cnt_q + VEC_W'(1);
        end
      end

      ST_CMP: begin
        state_d = ST_IDLE;
        fail_d  = verdict_fail;
        pass_d  = !verdict_fail;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      misr_q    <= 32'h0;
      vec_cnt_q <= '0;
      op_cnt_q  <= 4'h0;
      zerr_q    <= 8'h00;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      vec_cnt_q <= vec_cnt_d;
      op_cnt_q  <= op_cnt_d;
      zerr_q    <= zerr_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
    end
  end

  // Operands are only presented while vectors are being applied. Otherwise
  // the ALU sees a quiet all-zero input.
  assign bist_a       = (state_q == ST_RUN) ? lfsr_q : 32'h0;
  assign bist_b       = (state_q == ST_RUN) ? {lfsr_q[18:0], lfsr_q[31:19]} : 32'h0;
  assign bist_alu_op  = (state_q == ST_RUN) ? op_cnt_q : 4'h0;

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign signature    = misr_q;
  assign zero_err_cnt = zerr_q;

endmodule

// File: tb/tb_alu_bist.sv
// -----------------------------------------------------------------------------
// tb_alu_bist -- self-checking bench for alu_bist.
// dut0 uses the default geometry and has a reference ALU attached. Its
// GOLDEN_SIG is computed from the bench model at elaboration. dut1 uses
// NUM_VECTORS=32 and sees a forced all-zero result with the zero flag held
// low, so its zero-error counter must saturate.
// -----------------------------------------------------------------------------
module tb_alu_bist;

  localparam logic [31:0] SEED = 32'hACE1_1234;
  localparam int NV0 = 16;
  localparam int N0  = 10 * NV0;
  localparam int NV1 = 32;
  localparam int N1  = 10 * NV1;

  function automatic logic [31:0] m_lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] m_rotl13(input logic [31:0] s);
    return {s[18:0], s[31:19]};
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << b[4:0];
      4'd6:    r = a >> b[4:0];
      4'd7:    r = $unsigned($signed(a) >>> b[4:0]);
      4'd8:    r = {31'b0, ($signed(a) < $signed(b))};
      4'd9:    r = {31'b0, (a < b)};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Returns {zero_err_cnt, signature} expected after a full run.
  // mode 1: result forced 0 with zero flag forced 0.
  // Any other mode: reference ALU, with bit 8 of the result inverted on RUN
  // cycle flip_cyc (use -1 for no flip).
  function automatic logic [39:0] calc_run(input int nv, input int mode, input int flip_cyc);
    logic [31:0] l;
    logic [31:0] s;
    logic [31:0] r;
    logic [31:0] nx;
    logic        z;
    logic [7:0]  ze;
    l  = SEED;
    s  = 32'h0;
    ze = 8'h0;
    for (int i = 0; i < 10 * nv; i++) begin
      r = m_alu(4'(i / nv), l, m_rotl13(l));
      if (mode == 1) begin
        r = 32'h0;
        z = 1'b0;
      end else begin
        if (i == flip_cyc) r = r ^ 32'h0000_0100;
        z = (r == 32'h0);
      end
      nx    = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ r;
      nx[0] = nx[0] ^ z;
      s     = nx;
      if ((z != (r == 32'h0)) && (ze != 8'hFF)) ze = ze + 8'd1;
      l = m_lfsr_step(l);
    end
    return {ze, s};
  endfunction

  localparam logic [39:0] GOLD_M = calc_run(NV0, 0, -1);
  localparam logic [31:0] GOLD   = GOLD_M[31:0];

  typedef struct packed {
    logic [31:0] sig;
    logic [7:0]  zerr;
    logic        pass;
    logic        fail;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] b;
    logic [31:0] a;
  } vec_t;

  exp_t res_q[$];
  vec_t op_q[$];

  int errors = 0;
  int checks = 0;
  int done_cnt0 = 0;

  logic        clk;
  logic        rst;
  logic        start0, start1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic [31:0] res0, alu_ref0;
  logic        zero0;
  logic        busy0, done0, pass0, fail0;
  logic        busy1, done1, pass1, fail1;
  logic [31:0] sig0, sig1;
  logic [7:0]  zerr0, zerr1;
  int          alu_mode;
  logic        flip_now;

  alu_bist #(.NUM_OPS(10), .NUM_VECTORS(NV0), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .bist_a(a0), .bist_b(b0), .bist_alu_op(op0),
    .alu_result(res0), .alu_zero(zero0),
    .busy(busy0), .done(done0), .pass(pass0), .fail(fail0),
    .signature(sig0), .zero_err_cnt(zerr0)
  );

  alu_bist #(.NUM_OPS(10), .NUM_VECTORS(NV1), .LFSR_SEED(SEED), .GOLDEN_SIG(32'h0)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .bist_a(a1), .bist_b(b1), .bist_alu_op(op1),
    .alu_result(32'h0), .alu_zero(1'b0),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
    .signature(sig1), .zero_err_cnt(zerr1)
  );

  // Reference ALU for dut0, with forcing and single-cycle fault injection.
  always_comb begin
    alu_ref0 = m_alu(op0, a0, b0);
    res0     = alu_ref0;
    zero0    = 1'b0;
    if (alu_mode == 1) begin
      res0  = 32'h0;
      zero0 = 1'b0;
    end else begin
      res0  = flip_now ? (alu_ref0 ^ 32'h0000_0100) : alu_ref0;
      zero0 = (res0 == 32'h0);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done0) done_cnt0 <= done_cnt0 + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One full run on dut0. restart_cyc re-pulses start at that RUN cycle.
  // With hold set, start stays high through done.
  task automatic run0(input int mode, input int flip_cyc, input int restart_cyc, input bit hold);
    exp_t        e;
    vec_t        v;
    logic [39:0] m;
    logic [31:0] l;
    int          k;
    int          busy_n;
    bit          seen;
    m      = calc_run(NV0, mode, flip_cyc);
    e.sig  = m[31:0];
    e.zerr = m[39:32];
    e.fail = (m[31:0] != GOLD) || (m[39:32] != 8'h0);
    e.pass = !e.fail;
    res_q.push_back(e);
    l = SEED;
    for (int i = 0; i < N0; i++) begin
      op_q.push_back('{op: 4'(i / NV0), b: m_rotl13(l), a: l});
      l = m_lfsr_step(l);
    end
    alu_mode = (mode == 1) ? 1 : 0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk);
    busy_n = 0;
    seen   = 0;
    for (k = 0; k < 2 * N0 + 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k == restart_cyc) start0 = 1'b1;
      else if (!hold) start0 = 1'b0;
      flip_now = (mode == 2) && (k == flip_cyc);
      if (done0) begin
        seen = 1;
        break;
      end
      if (busy0) busy_n++;
      if (op_q.size() > 0) begin
        v = op_q.pop_front();
        check_eq("bist_a", a0, v.a);
        check_eq("bist_b", b0, v.b);
        check_eq("bist_alu_op", {28'h0, op0}, {28'h0, v.op});
      end
    end
    flip_now = 1'b0;
    check_eq("done_edge", k, N0 + 1);
    check_eq("busy_cycles", busy_n, N0 + 1);
    check_eq("ops_consumed", op_q.size(), 0);
    op_q.delete();
    e = res_q.pop_front();
    if (seen) begin
      check_eq("signature", sig0, e.sig);
      check_eq("zero_err_cnt", {24'h0, zerr0}, {24'h0, e.zerr});
      check_eq("pass", {31'h0, pass0}, {31'h0, e.pass});
      check_eq("fail", {31'h0, fail0}, {31'h0, e.fail});
      check_eq("idle_a_zero", a0, 32'h0);
      @(negedge clk);
      check_eq("done_one_cycle", {31'h0, done0}, 32'h0);
      if (hold) begin
        check_eq("held_start_restarts", {31'h0, busy0}, 32'h1);
      end else begin
        check_eq("pass_held", {31'h0, pass0}, {31'h0, e.pass});
        check_eq("sig_retained", sig0, e.sig);
      end
    end else begin
      check_eq("done_timeout", 32'h0, 32'h1);
    end
    $display("run mode=%0d flip=%0d restart=%0d hold=%0d sig=%08h zerr=%0d pass=%0d fail=%0d",
             mode, flip_cyc, restart_cyc, hold, sig0, zerr0, pass0, fail0);
  endtask

  initial begin
    int          dc;
    int          k;
    bit          seen;
    logic [39:0] m;
    exp_t        e;
    rst      = 1'b1;
    start0   = 1'b0;
    start1   = 1'b0;
    alu_mode = 0;
    flip_now = 1'b0;

    // Reset state.
    @(negedge clk);
    check_eq("rst_busy", {31'h0, busy0}, 32'h0);
    check_eq("rst_done", {31'h0, done0}, 32'h0);
    check_eq("rst_pass_fail", {30'h0, pass0, fail0}, 32'h0);
    check_eq("rst_a", a0, 32'h0);
    check_eq("rst_b", b0, 32'h0);
    check_eq("rst_sig", sig0, 32'h0);
    check_eq("rst_zerr", {24'h0, zerr0}, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("idle_no_start", {31'h0, busy0}, 32'h0);
    $display("reset checks done");

    // Golden run, forced zero flag, then a single-bit result fault.
    run0(0, -1, -1, 0);
    check_eq("golden_pass", {31'h0, pass0}, 32'h1);
    run0(1, -1, -1, 0);
    check_eq("forced_zerr_160", {24'h0, zerr0}, 32'd160);
    run0(2, 37, -1, 0);
    check_eq("flip_sig_ne_gold", {31'h0, (sig0 != GOLD)}, 32'h1);
    check_eq("flip_fail", {31'h0, fail0}, 32'h1);

    // Reset at RUN cycle 50 aborts the run.
    alu_mode = 0;
    dc = done_cnt0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("midrun_busy", {31'h0, busy0}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", {31'h0, busy0}, 32'h0);
    check_eq("abort_pass_fail", {30'h0, pass0, fail0}, 32'h0);
    check_eq("abort_ops", {op0, a0[27:0]} | b0, 32'h0);
    check_eq("abort_sig_zerr", sig0 | {24'h0, zerr0}, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (200) @(negedge clk);
    check_eq("abort_no_done", done_cnt0 - dc, 0);
    check_eq("abort_idle", {29'h0, busy0, pass0, fail0}, 32'h0);
    $display("midrun reset abort checked");

    // start re-pulsed mid-run must not restart; exactly one done.
    dc = done_cnt0;
    run0(0, -1, 80, 0);
    repeat (200) @(negedge clk);
    check_eq("restart_one_done", done_cnt0 - dc, 1);

    // start held high: new run on the edge after done.
    run0(0, -1, -1, 1);
    start0 = 1'b0;
    rst    = 1'b1;
    @(negedge clk) rst = 1'b0;

    // Saturation on dut1 (N = 320).
    m      = calc_run(NV1, 1, -1);
    e.sig  = m[31:0];
    e.zerr = m[39:32];
    e.fail = 1'b1;
    e.pass = 1'b0;
    res_q.push_back(e);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    seen = 0;
    for (k = 0; k < 2 * N1 + 10; k++) begin
      if (k > 0) @(negedge clk);
      if (done1) begin
        seen = 1;
        break;
      end
    end
    e = res_q.pop_front();
    check_eq("sat_done_edge", k, N1 + 1);
    check_eq("sat_seen", {31'h0, seen}, 32'h1);
    check_eq("sat_zerr_255", {24'h0, zerr1}, 32'd255);
    check_eq("sat_zerr_model", {24'h0, zerr1}, {24'h0, e.zerr});
    check_eq("sat_sig", sig1, e.sig);
    check_eq("sat_verdict", {30'h0, pass1, fail1}, {30'h0, e.pass, e.fail});
    check_eq("sat_idle_ops", a1 | b1 | {28'h0, op1} | {31'h0, busy1}, 32'h0);
    $display("saturation run zerr=%0d pass=%0d fail=%0d", zerr1, pass1, fail1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
